add_round_key_stage: RTL and testbench

- AES round-key addition stage. It sits directly upstream of the SubBytes stage and drives that stage's valid_in/data_in.
- It holds an on-chip iterative AES-128 key schedule. On key_load it expands the cipher key into 11 round keys, one per cycle, and stores them.
- Each accepted data beat is XORed with the stored round key selected by round_in. The result is registered and passed on with 1-cycle latency.

---
 rtl/add_round_key_stage_if.sv | 39 +++
 rtl/add_round_key_stage.sv | 213 +++++++++++++++++++++
 tb/tb_add_round_key_stage.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_stage_if.sv
// Bundles the key-load, data-beat and result signals of the AES round-key
// addition stage. The slave side is the stage itself; the master side is
// the upstream controller (or a bench) that loads keys and feeds beats.
//
// Signals:
//   key_load  : one-cycle pulse, samples key_in and starts key expansion
//   key_in    : cipher key, byte 0 in the top byte
//   key_ready : all round keys are valid
//   valid_in  : data beat present this cycle
//   round_in  : round-key index for the beat
//   data_in   : AES state, byte 0 in the top byte, column-major
//   valid_out : registered beat valid (feeds SubBytes valid_in)
//   data_out  : data_in XOR selected round key
//   round_out : round_in aligned with data_out
//   round_err : the beat on data_out carried an out-of-range round index
interface add_round_key_stage_if #(
    parameter int DATA_LEN = 128
);
    logic                key_load;
    logic [DATA_LEN-1:0] key_in;
    logic                key_ready;
    logic                valid_in;
    logic [3:0]          round_in;
    logic [DATA_LEN-1:0] data_in;
    logic                valid_out;
    logic [DATA_LEN-1:0] data_out;
    logic [3:0]          round_out;
    logic                round_err;

    modport master (
        output key_load, key_in, valid_in, round_in, data_in,
        input  key_ready, valid_out, data_out, round_out, round_err
    );

    modport slave (
        input  key_load, key_in, valid_in, round_in, data_in,
        output key_ready, valid_out, data_out, round_out, round_err
    );
endinterface

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with an on-chip iterative key schedule.
// Latency: 1 cycle data_in -> data_out; key expansion takes 10 cycles after key_load.
// Backpressure: none; downstream always accepts, beats arriving before key_ready are dropped.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : add_round_key_stage_if.slave (key load, data beat in, result out)
//
// The 11 round keys live in a small register array. On key_load, rk[0] is
// written with the cipher key; each following cycle writes rk[cnt] from
// rk[cnt-1] until rk[NUM_ROUNDS] is done, at which point key_ready rises.
module add_round_key_stage #(
    parameter int DATA_LEN   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    add_round_key_stage_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] msb_pos;
        msb_pos = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[msb_pos -: 8];
    endfunction

    // Four independent byte lookups; no SubBytes instance is shared here.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [7:0]          rcon_q;

    logic [DATA_LEN-1:0] rk [0:NUM_ROUNDS];

    logic                rk_wr_en;
    logic [3:0]          rk_wr_idx;
    logic [DATA_LEN-1:0] rk_wr_dat;

    logic [3:0]          prev_idx;
    logic [DATA_LEN-1:0] prev_key;
    logic [DATA_LEN-1:0] next_key;
    logic [31:0]         w0;
    logic [31:0]         w1;
    logic [31:0]         w2;
    logic [31:0]         w3;
    logic [31:0]         temp;

    logic                key_ready;
    logic                beat_acc;
    logic [3:0]          rd_idx;
    logic [DATA_LEN-1:0] rd_key;

    logic                valid_q;
    logic [DATA_LEN-1:0] data_q;
    logic [3:0]          round_q;
    logic                err_q;

    // ---------------------------------------------------------------
    // Key schedule datapath: one round key per cycle from the previous.
    // ---------------------------------------------------------------
    assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign prev_key = rk[prev_idx];

    assign temp = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h000000};
    assign w0   = prev_key[127:96] ^ temp;
    assign w1   = prev_key[95:64]  ^ w0;
    assign w2   = prev_key[63:32]  ^ w1;
    assign w3   = prev_key[31:0]   ^ w2;
    assign next_key = {w0, w1, w2, w3};

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rk_wr_en  = 1'b0;
        rk_wr_idx = cnt_q;
        rk_wr_dat = next_key;

        case (state_q)
            IDLE, READY: begin
                if (bus.key_load) begin
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (!bus.key_load) begin
                    rk_wr_en = 1'b1;
                    if (cnt_q == LAST_RND) begin
                        state_d = READY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new key always overrides whatever expansion step was due.
        if (bus.key_load) begin
            state_d   = EXPAND;
            rk_wr_en  = 1'b1;
            rk_wr_idx = 4'd0;
            rk_wr_dat = bus.key_in;
        end
    end

    // Expansion counter and Rcon; cnt is the index written on the next step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 4'd0;
            rcon_q <= 8'h01;
        end else if (bus.key_load) begin
            cnt_q  <= 4'd1;
            rcon_q <= 8'h01;
        end else if (state_q == EXPAND) begin
            cnt_q  <= cnt_q + 4'd1;
            rcon_q <= xtime(rcon_q);
        end
    end

    // Round-key storage; contents are meaningless until key_ready.
    always_ff @(posedge clk) begin
        if (rk_wr_en) begin
            rk[rk_wr_idx] <= rk_wr_dat;
        end
    end

    // ---------------------------------------------------------------
    // Data path. key_ready is taken from the registered state, so a beat
    // that coincides with key_load while READY still sees the old keys
    // (rk[0] is only overwritten at that same edge).
    // ---------------------------------------------------------------
    assign key_ready = (state_q == READY);
    assign beat_acc  = bus.valid_in && key_ready;
    assign rd_idx    = (bus.round_in > LAST_RND) ? 4'd0 : bus.round_in;
    assign rd_key    = rk[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            round_q <= 4'd0;
            err_q   <= 1'b0;
        end else if (beat_acc) begin
            valid_q <= 1'b1;
            round_q <= bus.round_in;
            if (bus.round_in > LAST_RND) begin
                data_q <= bus.data_in;
                err_q  <= 1'b1;
            end else begin
                data_q <= bus.data_in ^ rd_key;
                err_q  <= 1'b0;
            end
        end else begin
            // Dropped or absent beat: only valid falls, payload holds.
            valid_q <= 1'b0;
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.round_out = round_q;
    assign bus.round_err = err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: FIPS-197 vectors, a table of streaming
// beats, randomized beats against a reference key schedule built from
// GF(2^8) arithmetic, and hand-written reset / key_load collision sequences.
module tb_add_round_key_stage;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_R0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] BAD_DAT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DEAD_DAT = 128'hdeadbeef0123456789abcdeffedcba98;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    add_round_key_stage_if #(.DATA_LEN(128)) bus ();

    add_round_key_stage #(.DATA_LEN(128), .NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   ref_sbox [256];
    logic [127:0] model_rk [11];

    // ------------------------- reference model -------------------------
    function automatic logic [7:0] gf_xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Word-oriented FIPS-197 key expansion into model_rk.
    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gf_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ------------------------------ helpers -----------------------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        step();
        bus.key_load = 1'b0;
    endtask

    // Called right after the load edge; counts cycles with key_ready low.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.key_ready && n < 40) begin
            n++;
            step();
        end
        check(name, 128'(n), 128'd10);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic         vld;
        logic [3:0]   rnd;
        logic [127:0] dat;
        logic         exp_vld;
        logic [127:0] exp_dat;
        logic [3:0]   exp_rnd;
        logic         exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        logic [127:0] d;
        logic [3:0]   r;
        logic         v;
        logic         m_vld;
        logic [127:0] m_dat;
        logic [3:0]   m_rnd;
        logic         m_err;

        vecs[0] = '{1'b1, 4'd0,  128'h0,   1'b1, FIPS_KEY,  4'd0,  1'b0};
        vecs[1] = '{1'b1, 4'd1,  128'h0,   1'b1, FIPS_RK1,  4'd1,  1'b0};
        vecs[2] = '{1'b1, 4'd10, 128'h0,   1'b1, FIPS_RK10, 4'd10, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  128'h0,   1'b1, FIPS_KEY,  4'd0,  1'b0};
        vecs[4] = '{1'b1, 4'd11, BAD_DAT,  1'b1, BAD_DAT,   4'd11, 1'b1};
        vecs[5] = '{1'b0, 4'd3,  DEAD_DAT, 1'b0, BAD_DAT,   4'd11, 1'b1};
        vecs[6] = '{1'b1, 4'd15, DEAD_DAT, 1'b1, DEAD_DAT,  4'd15, 1'b1};
        vecs[7] = '{1'b1, 4'd2,  128'h0,   1'b1, FIPS_RK2,  4'd2,  1'b0};

        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_calc(8'(i));

        reset        = 1'b0;
        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.valid_in = 1'b0;
        bus.round_in = 4'd0;
        bus.data_in  = '0;

        // Reset state
        step();
        step();
        check("rst_key_ready", 128'(bus.key_ready), 128'd0);
        check("rst_valid_out", 128'(bus.valid_out), 128'd0);
        check("rst_data_out",  bus.data_out,        128'd0);
        check("rst_round_out", 128'(bus.round_out), 128'd0);
        check("rst_round_err", 128'(bus.round_err), 128'd0);
        reset = 1'b1;
        step();

        // FIPS key with beats offered throughout expansion: all dropped.
        bus.valid_in = 1'b1;
        bus.round_in = 4'd0;
        bus.data_in  = rand128();
        do_load(FIPS_KEY);
        for (int i = 0; i < 10; i++) begin
            check("exp_key_ready_low", 128'(bus.key_ready), 128'd0);
            check("exp_valid_low",     128'(bus.valid_out), 128'd0);
            check("exp_data_held",     bus.data_out,        128'd0);
            bus.data_in = rand128();
            step();
        end
        check("exp_key_ready_high", 128'(bus.key_ready), 128'd1);
        check("exp_last_drop",      128'(bus.valid_out), 128'd0);

        // First beat after ready: FIPS round 0
        bus.data_in = FIPS_PT;
        step();
        check("r0_valid", 128'(bus.valid_out), 128'd1);
        check("r0_data",  bus.data_out,        FIPS_R0);
        check("r0_round", 128'(bus.round_out), 128'd0);
        check("r0_err",   128'(bus.round_err), 128'd0);

        // Table: streaming, bad round, hold on idle, recovery
        for (int i = 0; i < 8; i++) begin
            bus.valid_in = vecs[i].vld;
            bus.round_in = vecs[i].rnd;
            bus.data_in  = vecs[i].dat;
            step();
            check($sformatf("vec%0d_valid", i), 128'(bus.valid_out), 128'(vecs[i].exp_vld));
            check($sformatf("vec%0d_data", i),  bus.data_out,        vecs[i].exp_dat);
            check($sformatf("vec%0d_round", i), 128'(bus.round_out), 128'(vecs[i].exp_rnd));
            check($sformatf("vec%0d_err", i),   128'(bus.round_err), 128'(vecs[i].exp_err));
        end
        bus.valid_in = 1'b0;

        // Randomized beats under a random key
        k = rand128();
        do_load(k);
        ref_expand(k);
        wait_ready("rand_ready_latency");
        step();
        m_vld = 1'b0;
        m_dat = bus.data_out;
        m_rnd = bus.round_out;
        m_err = bus.round_err;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = 4'($urandom_range(0, 15));
            d = rand128();
            bus.valid_in = v;
            bus.round_in = r;
            bus.data_in  = d;
            step();
            m_vld = v;
            if (v) begin
                m_rnd = r;
                m_err = (r > 4'd10);
                m_dat = m_err ? d : (d ^ model_rk[r]);
            end
            check("rand_valid", 128'(bus.valid_out), 128'(m_vld));
            check("rand_data",  bus.data_out,        m_dat);
            check("rand_round", 128'(bus.round_out), 128'(m_rnd));
            check("rand_err",   128'(bus.round_err), 128'(m_err));
        end

        // key_load with a beat while READY: beat uses the old keys
        d = rand128();
        m_dat = d ^ model_rk[5];
        bus.valid_in = 1'b1;
        bus.round_in = 4'd5;
        bus.data_in  = d;
        k = rand128();
        do_load(k);
        bus.valid_in = 1'b0;
        check("coll_valid",     128'(bus.valid_out), 128'd1);
        check("coll_data",      bus.data_out,        m_dat);
        check("coll_key_ready", 128'(bus.key_ready), 128'd0);
        ref_expand(k);
        wait_ready("coll_ready_latency");
        d = rand128();
        bus.valid_in = 1'b1;
        bus.round_in = 4'd7;
        bus.data_in  = d;
        step();
        bus.valid_in = 1'b0;
        check("coll_newkey_data", bus.data_out, d ^ model_rk[7]);

        // Reset during expansion
        k = rand128();
        do_load(k);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b0;
        #1;
        check("mid_rst_key_ready", 128'(bus.key_ready), 128'd0);
        check("mid_rst_valid",     128'(bus.valid_out), 128'd0);
        check("mid_rst_data",      bus.data_out,        128'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("post_rst_not_ready", 128'(bus.key_ready), 128'd0);

        // Reload after reset
        k = rand128();
        do_load(k);
        ref_expand(k);
        wait_ready("reload_ready_latency");
        d = rand128();
        bus.valid_in = 1'b1;
        bus.round_in = 4'd10;
        bus.data_in  = d;
        step();
        bus.valid_in = 1'b0;
        check("reload_valid", 128'(bus.valid_out), 128'd1);
        check("reload_data",  bus.data_out,        d ^ model_rk[10]);
        step();
        check("reload_idle_valid", 128'(bus.valid_out), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
